// File: rtl/encoder_arb_pkg.sv
// Shared types and default parameters for the encoder arbiter.
// Optional timeout support is enabled with ENCODER_ARB_TIMEOUT_EN.
package encoder_arb_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_RES_W       = 3;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// and cyclically from last_grant+1. Returns one-hot winner, its index and valid.
module rr_pick
    import encoder_arb_pkg::*;
#(
    parameter int N    = DEF_N_REQ,
    parameter int LG_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [LG_W-1:0] last_grant,
    output logic [N-1:0]    winner,
    output logic [LG_W-1:0] winner_idx,
    output logic            valid
);

    logic [LG_W-1:0] cand;

    // Offset 1..N so the previous winner is examined last.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = LG_W'((32'(last_grant) + 32'(i)) % 32'(N));
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner_idx   = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_arbiter.sv
// Round-robin arbiter sharing one encoder among N_REQ requesters.
// Define ENCODER_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles with rsp_err.
module encoder_arbiter
    import encoder_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RES_W       = DEF_RES_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    enc_start,
    output logic [DATA_W-1:0]       enc_data,
    input  logic                    enc_done,
    input  logic [RES_W-1:0]        enc_result,
    output logic                    busy
);

    localparam int LG_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("encoder_arbiter: unsupported N_REQ or TIMEOUT_CYC");
    end

    state_t            state;
    logic [LG_W-1:0]   last_grant;
    logic [N_REQ-1:0]  pick_onehot;
    logic [LG_W-1:0]   pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] pick_word;
    logic              to_fire;

    rr_pick #(
        .N    (N_REQ),
        .LG_W (LG_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) pick_word = req_data[i*DATA_W +: DATA_W];
        end
    end

`ifdef ENCODER_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Counter is zero during the first WAIT cycle; fires in the TIMEOUT_CYC-th one.
    assign to_fire = (state == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign rsp_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ISSUE)
                to_cnt <= '0;
            else if (state == WAIT && !to_fire)
                to_cnt <= to_cnt + 1'b1;
            // A done arriving with the timeout wins, so no error then.
            if (state == WAIT)
                err_q <= to_fire && !enc_done;
        end
    end
`else
    assign to_fire = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LG_W'(N_REQ - 1);
            gnt        <= '0;
            enc_data   <= '0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= ISSUE;
                        gnt        <= pick_onehot;
                        enc_data   <= pick_word;
                        last_grant <= pick_idx;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (enc_done) begin
                        state    <= RESP;
                        rsp_data <= enc_result;
                    end else if (to_fire) begin
                        state    <= RESP;
                        rsp_data <= '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign enc_start = (state == ISSUE);
    assign rsp_valid = (state == RESP) ? gnt : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_encoder_arbiter.sv
// Directed bench for encoder_arbiter; the bench plays the shared encoder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_encoder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [2:0]  rsp_data;
    logic        rsp_err;
    logic        enc_start;
    logic [7:0]  enc_data;
    logic        enc_done;
    logic [2:0]  enc_result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    encoder_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .enc_start  (enc_start),
        .enc_data   (enc_data),
        .enc_done   (enc_done),
        .enc_result (enc_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ":gnt"}, gnt, 0);
        check({tag, ":rsp_valid"}, rsp_valid, 0);
        check({tag, ":rsp_data"}, rsp_data, 0);
        check({tag, ":rsp_err"}, rsp_err, 0);
        check({tag, ":enc_start"}, enc_start, 0);
        check({tag, ":enc_data"}, enc_data, 0);
        check({tag, ":busy"}, busy, 0);
    endtask

    // One full transaction: enc_done is raised in WAIT cycle w.
    task automatic txn(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt,
                       input logic [7:0] exp_word, input int w, input logic [2:0] res,
                       input bit drop);
        req = r;
        tick;
        check({tag, ":issue_gnt"}, gnt, exp_gnt);
        check({tag, ":issue_start"}, enc_start, 1);
        check({tag, ":issue_data"}, enc_data, exp_word);
        check({tag, ":issue_busy"}, busy, 1);
        check({tag, ":issue_rsp"}, rsp_valid, 0);
        if (drop) req = '0;
        tick;
        check({tag, ":wait_start"}, enc_start, 0);
        for (int k = 1; k <= w; k++) begin
            check({tag, ":wait_rsp"}, rsp_valid, 0);
            check({tag, ":wait_gnt"}, gnt, exp_gnt);
            if (k == w) begin
                enc_done   = 1'b1;
                enc_result = res;
            end
            tick;
        end
        enc_done   = 1'b0;
        enc_result = '0;
        check({tag, ":resp_valid"}, rsp_valid, exp_gnt);
        check({tag, ":resp_data"}, rsp_data, res);
        check({tag, ":resp_err"}, rsp_err, 0);
        check({tag, ":resp_enc_data"}, enc_data, exp_word);
        check({tag, ":resp_busy"}, busy, 1);
        tick;
        check({tag, ":end_rsp"}, rsp_valid, 0);
        check({tag, ":end_gnt"}, gnt, 0);
        check({tag, ":end_busy"}, busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        enc_done   = 1'b0;
        enc_result = '0;
        tick;
        tick;
        check_idle_outputs("reset");
        rst = 1'b0;

        // Full contention: 0,1,2,3 then wrap to 0.
        txn("rr0", 4'b1111, 4'b0001, 8'h11, 1, 3'd1, 1'b0);
        txn("rr1", 4'b1111, 4'b0010, 8'h22, 1, 3'd2, 1'b0);
        txn("rr2", 4'b1111, 4'b0100, 8'hA5, 1, 3'd3, 1'b0);
        txn("rr3", 4'b1111, 4'b1000, 8'h44, 1, 3'd4, 1'b0);
        txn("rr4", 4'b1111, 4'b0001, 8'h11, 1, 3'd5, 1'b0);

        txn("single2", 4'b0100, 4'b0100, 8'hA5, 3, 3'd5, 1'b0);

        // last_grant becomes 3, then 1001 must wrap to index 0 first.
        txn("set3", 4'b1000, 4'b1000, 8'h44, 2, 3'd7, 1'b0);
        txn("wrap0", 4'b1001, 4'b0001, 8'h11, 1, 3'd6, 1'b0);
        txn("wrap3", 4'b1001, 4'b1000, 8'h44, 1, 3'd2, 1'b0);

        // Requester drops req after ISSUE and is still answered.
        txn("drop1", 4'b0010, 4'b0010, 8'h22, 2, 3'd4, 1'b1);

        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("noreq:busy", busy, 0);
            check("noreq:start", enc_start, 0);
        end
        // last_grant still 1, so index 2 is next.
        txn("after_idle", 4'b1111, 4'b0100, 8'hA5, 1, 3'd1, 1'b0);

        // Reset while in WAIT, then a stray done.
        req = 4'b0010;
        tick;
        check("rstw:gnt", gnt, 4'b0010);
        tick;
        check("rstw:busy", busy, 1);
        rst = 1'b1;
        req = '0;
        tick;
        check_idle_outputs("rstw");
        rst      = 1'b0;
        enc_done = 1'b1;
        enc_result = 3'd7;
        tick;
        enc_done   = 1'b0;
        enc_result = '0;
        check("rstw:stray_rsp", rsp_valid, 0);
        check("rstw:stray_busy", busy, 0);
        txn("rstw_next", 4'b1111, 4'b0001, 8'h11, 1, 3'd3, 1'b0);

        // Stray done in IDLE must not complete the next transaction early.
        req      = '0;
        enc_done = 1'b1;
        tick;
        enc_done = 1'b0;
        check("stray:busy", busy, 0);
        txn("stray_next", 4'b0010, 4'b0010, 8'h22, 4, 3'd6, 1'b0);

`ifdef ENCODER_ARB_TIMEOUT_EN
        req = 4'b0001;
        tick;
        check("to:gnt", gnt, 4'b0001);
        req = '0;
        tick;
        for (int k = 1; k <= 16; k++) begin
            check("to:wait_rsp", rsp_valid, 0);
            tick;
        end
        check("to:rsp_valid", rsp_valid, 4'b0001);
        check("to:rsp_err", rsp_err, 1);
        check("to:rsp_data", rsp_data, 0);
        tick;
        check("to:end_busy", busy, 0);
        // Done in the same cycle as the timeout wins.
        txn("to_tie", 4'b0001, 4'b0001, 8'h11, 16, 3'd6, 1'b0);
`else
        // No timeout in this build: a long wait still completes normally.
        txn("long", 4'b0001, 4'b0001, 8'h11, 20, 3'd6, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
